// File: rtl/axi4lite_rr_arbiter_if.sv
// Purpose: bundles the N upstream AXI4-Lite master ports (s_*) and the single
// downstream slave port (m_*) of axi4lite_rr_arbiter.
// Master i occupies slice i of every s_* vector, and bit i of each s_* ready/valid.
// Modports:
//   slave  - the arbiter side (a slave to the upstream masters and the master of the downstream port)
//   master - the environment side (the upstream masters plus the downstream slave)
interface axi4lite_rr_arbiter_if #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // upstream (one slice per master)
  logic [N_MASTERS-1:0]        s_aw_valid, s_aw_ready;
  logic [N_MASTERS*ADDR_W-1:0] s_aw_addr;
  logic [N_MASTERS*3-1:0]      s_aw_prot;
  logic [N_MASTERS-1:0]        s_w_valid, s_w_ready;
  logic [N_MASTERS*DATA_W-1:0] s_w_data;
  logic [N_MASTERS*STRB_W-1:0] s_w_strb;
  logic [N_MASTERS-1:0]        s_b_valid, s_b_ready;
  logic [N_MASTERS*2-1:0]      s_b_resp;
  logic [N_MASTERS-1:0]        s_ar_valid, s_ar_ready;
  logic [N_MASTERS*ADDR_W-1:0] s_ar_addr;
  logic [N_MASTERS*3-1:0]      s_ar_prot;
  logic [N_MASTERS-1:0]        s_r_valid, s_r_ready;
  logic [N_MASTERS*DATA_W-1:0] s_r_data;
  logic [N_MASTERS*2-1:0]      s_r_resp;

  // downstream (single slave)
  logic              m_aw_valid, m_aw_ready;
  logic [ADDR_W-1:0] m_aw_addr;
  logic [2:0]        m_aw_prot;
  logic              m_w_valid, m_w_ready;
  logic [DATA_W-1:0] m_w_data;
  logic [STRB_W-1:0] m_w_strb;
  logic              m_b_valid, m_b_ready;
  logic [1:0]        m_b_resp;
  logic              m_ar_valid, m_ar_ready;
  logic [ADDR_W-1:0] m_ar_addr;
  logic [2:0]        m_ar_prot;
  logic              m_r_valid, m_r_ready;
  logic [DATA_W-1:0] m_r_data;
  logic [1:0]        m_r_resp;

  modport slave (
    input  s_aw_valid, s_aw_addr, s_aw_prot, s_w_valid, s_w_data, s_w_strb, s_b_ready,
           s_ar_valid, s_ar_addr, s_ar_prot, s_r_ready,
    output s_aw_ready, s_w_ready, s_b_valid, s_b_resp, s_ar_ready, s_r_valid, s_r_data, s_r_resp,
    output m_aw_valid, m_aw_addr, m_aw_prot, m_w_valid, m_w_data, m_w_strb, m_b_ready,
           m_ar_valid, m_ar_addr, m_ar_prot, m_r_ready,
    input  m_aw_ready, m_w_ready, m_b_valid, m_b_resp, m_ar_ready, m_r_valid, m_r_data, m_r_resp
  );

  modport master (
    output s_aw_valid, s_aw_addr, s_aw_prot, s_w_valid, s_w_data, s_w_strb, s_b_ready,
           s_ar_valid, s_ar_addr, s_ar_prot, s_r_ready,
    input  s_aw_ready, s_w_ready, s_b_valid, s_b_resp, s_ar_ready, s_r_valid, s_r_data, s_r_resp,
    input  m_aw_valid, m_aw_addr, m_aw_prot, m_w_valid, m_w_data, m_w_strb, m_b_ready,
           m_ar_valid, m_ar_addr, m_ar_prot, m_r_ready,
    output m_aw_ready, m_w_ready, m_b_valid, m_b_resp, m_ar_ready, m_r_valid, m_r_data, m_r_resp
  );
endinterface

// File: rtl/axi4lite_rr_arbiter.sv
// Purpose: shares one AXI4-Lite slave between N_MASTERS AXI4-Lite masters.
// Exactly one whole transaction (a read or a write) is in flight at a time.
// Masters are granted round-robin. The response goes back to the granted master only.
// Ports:
//   clk    - clock
//   rstn   - synchronous, active-low reset
//   io_bus - axi4lite_rr_arbiter_if.slave (s_* upstream slices, m_* downstream port)
// Configuration macro:
//   AXI4LITE_ARB_FIXED_PRIO_EN - when defined, uses fixed priority (the lowest index wins)
//   and holds rr_ptr at 0. Grant timing is the same in both modes.
module axi4lite_rr_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64
) (
  input logic                  clk,
  input logic                  rstn,
  axi4lite_rr_arbiter_if.slave io_bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned GW     = (N_MASTERS > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_ADDR, ST_WR_RESP, ST_RD_ADDR, ST_RD_RESP
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_rr_ptr;
  logic            r_aw_done;
  logic            r_w_done;

  logic [N_MASTERS-1:0] w_wreq, w_rreq, w_req;
  logic                 w_win_any, w_win_wr;
  logic [GW-1:0]        w_win_idx, w_rr_ptr_nxt;
  logic                 w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic                 w_aw_done_nxt, w_w_done_nxt;

  // A write only requests once both AW and W are presented.
  assign w_wreq = io_bus.s_aw_valid & io_bus.s_w_valid;
  assign w_rreq = io_bus.s_ar_valid;
  assign w_req  = w_wreq | w_rreq;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int unsigned k);
    return GW'((32'(base) + k) % N_MASTERS);
  endfunction

  // Scan from rr_ptr upward (mod N); the first requester wins, and a write beats a read.
  always_comb begin
    w_win_any = 1'b0;
    w_win_wr  = 1'b0;
    w_win_idx = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (!w_win_any && w_req[rr_idx(r_rr_ptr, k)]) begin
        w_win_any = 1'b1;
        w_win_idx = rr_idx(r_rr_ptr, k);
        w_win_wr  = w_wreq[rr_idx(r_rr_ptr, k)];
      end
    end
  end

`ifdef AXI4LITE_ARB_FIXED_PRIO_EN
  assign w_rr_ptr_nxt = '0;
`else
  assign w_rr_ptr_nxt = (32'(r_grant) == N_MASTERS - 1) ? '0 : r_grant + GW'(1);
`endif

  assign w_aw_hs       = io_bus.m_aw_valid & io_bus.m_aw_ready;
  assign w_w_hs        = io_bus.m_w_valid  & io_bus.m_w_ready;
  assign w_b_hs        = io_bus.m_b_valid  & io_bus.m_b_ready;
  assign w_ar_hs       = io_bus.m_ar_valid & io_bus.m_ar_ready;
  assign w_r_hs        = io_bus.m_r_valid  & io_bus.m_r_ready;
  assign w_aw_done_nxt = r_aw_done | w_aw_hs;
  assign w_w_done_nxt  = r_w_done  | w_w_hs;

  // Transaction FSM: grant, address phase(s), response phase.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_any) begin
            r_grant <= w_win_idx;
            r_state <= w_win_wr ? ST_WR_ADDR : ST_RD_ADDR;
          end
        end
        ST_WR_ADDR: begin
          r_aw_done <= w_aw_done_nxt;
          r_w_done  <= w_w_done_nxt;
          if (w_aw_done_nxt && w_w_done_nxt) r_state <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (w_b_hs) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        ST_RD_ADDR: begin
          if (w_ar_hs) r_state <= ST_RD_RESP;
        end
        ST_RD_RESP: begin
          if (w_r_hs) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_rr_ptr_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Route the granted slice to the downstream port and back; every other slice stays quiet.
  always_comb begin
    io_bus.s_aw_ready = '0;
    io_bus.s_w_ready  = '0;
    io_bus.s_b_valid  = '0;
    io_bus.s_b_resp   = '0;
    io_bus.s_ar_ready = '0;
    io_bus.s_r_valid  = '0;
    io_bus.s_r_data   = '0;
    io_bus.s_r_resp   = '0;
    io_bus.m_aw_valid = 1'b0;
    io_bus.m_aw_addr  = '0;
    io_bus.m_aw_prot  = '0;
    io_bus.m_w_valid  = 1'b0;
    io_bus.m_w_data   = '0;
    io_bus.m_w_strb   = '0;
    io_bus.m_b_ready  = 1'b0;
    io_bus.m_ar_valid = 1'b0;
    io_bus.m_ar_addr  = '0;
    io_bus.m_ar_prot  = '0;
    io_bus.m_r_ready  = 1'b0;
    case (r_state)
      ST_WR_ADDR: begin
        if (!r_aw_done) begin
          io_bus.m_aw_valid          = io_bus.s_aw_valid[r_grant];
          io_bus.m_aw_addr           = io_bus.s_aw_addr[r_grant*ADDR_W +: ADDR_W];
          io_bus.m_aw_prot           = io_bus.s_aw_prot[r_grant*3 +: 3];
          io_bus.s_aw_ready[r_grant] = io_bus.m_aw_ready;
        end
        if (!r_w_done) begin
          io_bus.m_w_valid          = io_bus.s_w_valid[r_grant];
          io_bus.m_w_data           = io_bus.s_w_data[r_grant*DATA_W +: DATA_W];
          io_bus.m_w_strb           = io_bus.s_w_strb[r_grant*STRB_W +: STRB_W];
          io_bus.s_w_ready[r_grant] = io_bus.m_w_ready;
        end
      end
      ST_WR_RESP: begin
        io_bus.m_b_ready                 = io_bus.s_b_ready[r_grant];
        io_bus.s_b_valid[r_grant]        = io_bus.m_b_valid;
        io_bus.s_b_resp[r_grant*2 +: 2]  = io_bus.m_b_resp;
      end
      ST_RD_ADDR: begin
        io_bus.m_ar_valid          = io_bus.s_ar_valid[r_grant];
        io_bus.m_ar_addr           = io_bus.s_ar_addr[r_grant*ADDR_W +: ADDR_W];
        io_bus.m_ar_prot           = io_bus.s_ar_prot[r_grant*3 +: 3];
        io_bus.s_ar_ready[r_grant] = io_bus.m_ar_ready;
      end
      ST_RD_RESP: begin
        io_bus.m_r_ready                        = io_bus.s_r_ready[r_grant];
        io_bus.s_r_valid[r_grant]               = io_bus.m_r_valid;
        io_bus.s_r_data[r_grant*DATA_W +: DATA_W] = io_bus.m_r_data;
        io_bus.s_r_resp[r_grant*2 +: 2]         = io_bus.m_r_resp;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_axi4lite_rr_arbiter.sv
// Purpose: self-checking bench for axi4lite_rr_arbiter with N_MASTERS=2, ADDR_W=32, DATA_W=64.
// It is table-driven and cycle by cycle: each record holds the handshake inputs for one
// cycle and the handshake outputs expected in that cycle.
// Hand-written sequences cover reset, payload routing, the round-robin order, write-before-read
// priority, upstream backpressure, and reset during a response.
module tb_axi4lite_rr_arbiter;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

`ifdef AXI4LITE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [63:0] R_DATA = 64'hDEAD_BEEF_CAFE_F00D;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  axi4lite_rr_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  axi4lite_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in : {s_aw_valid, s_w_valid, s_ar_valid, s_b_ready, s_r_ready,
  //       m_aw_ready, m_w_ready, m_b_valid, m_ar_ready, m_r_valid}
  // exp: {m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready,
  //       s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid}
  typedef struct {
    logic [14:0] in;
    logic [14:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic drive(input logic [14:0] v);
    {bus.s_aw_valid, bus.s_w_valid, bus.s_ar_valid, bus.s_b_ready, bus.s_r_ready,
     bus.m_aw_ready, bus.m_w_ready, bus.m_b_valid, bus.m_ar_ready, bus.m_r_valid} = v;
  endtask

  function automatic logic [14:0] outs();
    return {bus.m_aw_valid, bus.m_w_valid, bus.m_ar_valid, bus.m_b_ready, bus.m_r_ready,
            bus.s_aw_ready, bus.s_w_ready, bus.s_b_valid, bus.s_ar_ready, bus.s_r_valid};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    drive('0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [1:0] g;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    g = FIXED ? 2'b01 : 2'b10;

    bus.s_aw_addr = {32'h9000_0000, 32'h8000_0000};
    bus.s_aw_prot = {3'b010, 3'b001};
    bus.s_w_data  = {64'hAAAA_BBBB_CCCC_DDDD, 64'h1122_3344_5566_7788};
    bus.s_w_strb  = {8'h0F, 8'hFF};
    bus.s_ar_addr = {32'h2000_0000, 32'h1000_0000};
    bus.s_ar_prot = {3'b110, 3'b100};
    bus.m_b_resp  = 2'b00;
    bus.m_r_data  = R_DATA;
    bus.m_r_resp  = 2'b10;

    vecs[0]  = '{15'b01_01_00_01_00_1_1_0_0_0, 15'b0_0_0_0_0_00_00_00_00_00};
    vecs[1]  = '{15'b01_01_00_01_00_1_1_0_0_0, 15'b1_1_0_0_0_01_01_00_00_00};
    vecs[2]  = '{15'b00_00_00_01_00_1_1_1_0_0, 15'b0_0_0_1_0_00_00_01_00_00};
    vecs[3]  = '{15'b00_00_11_00_11_0_0_0_1_0, 15'b0_0_0_0_0_00_00_00_00_00};
    vecs[4]  = '{15'b00_00_11_00_11_0_0_0_1_0, {5'b00100, 6'b000000, g, 2'b00}};
    vecs[5]  = '{15'b00_00_11_00_11_0_0_0_1_1, {5'b00001, 6'b000000, 2'b00, g}};
    vecs[6]  = '{15'b00_00_11_00_11_0_0_0_1_0, 15'b0_0_0_0_0_00_00_00_00_00};
    vecs[7]  = '{15'b00_00_11_00_11_0_0_0_1_0, 15'b0_0_1_0_0_00_00_00_01_00};
    vecs[8]  = '{15'b00_00_11_00_00_0_0_0_1_1, 15'b0_0_0_0_0_00_00_00_00_01};
    vecs[9]  = '{15'b00_00_00_00_01_0_0_0_1_1, 15'b0_0_0_0_1_00_00_00_00_01};
    vecs[10] = '{15'b10_10_00_10_00_1_0_0_0_0, 15'b0_0_0_0_0_00_00_00_00_00};
    vecs[11] = '{15'b10_10_01_10_00_1_0_0_0_0, 15'b1_1_0_0_0_10_00_00_00_00};
    vecs[12] = '{15'b10_10_01_10_00_1_0_0_0_0, 15'b0_1_0_0_0_00_00_00_00_00};
    vecs[13] = '{15'b10_10_01_10_00_1_0_0_0_0, 15'b0_1_0_0_0_00_00_00_00_00};
    vecs[14] = '{15'b00_10_01_10_00_1_1_0_0_0, 15'b0_1_0_0_0_00_10_00_00_00};
    vecs[15] = '{15'b00_00_01_10_00_1_1_1_0_0, 15'b0_0_0_1_0_00_00_10_00_00};
    vecs[16] = '{15'b00_00_01_00_01_0_0_0_1_0, 15'b0_0_0_0_0_00_00_00_00_00};
    vecs[17] = '{15'b00_00_01_00_01_0_0_0_1_0, 15'b0_0_1_0_0_00_00_00_01_00};
    vecs[18] = '{15'b00_00_00_00_01_0_0_0_1_1, 15'b0_0_0_0_1_00_00_00_00_01};
    vecs[19] = '{15'b00_00_00_00_00_0_0_0_0_0, 15'b0_0_0_0_0_00_00_00_00_00};

    // Reset held for two edges, with every upstream valid and downstream ready high.
    rstn = 1'b0;
    drive('1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk($sformatf("reset_quiet%0d", i), 64'(outs()), 64'(0));
    end
    @(negedge clk);
    drive('0);
    rstn = 1'b1;

    // Cycle-by-cycle vector table.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].in);
      #1;
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
    end

    // Payload routing: an M0 write, then an M1 read with an SLVERR response.
    reset_dut();
    drive(15'b01_01_00_01_00_0_0_0_0_0);
    #1 chk("pay_idle", 64'(outs()), 64'(0));
    @(negedge clk); #1;
    chk("pay_aw_w_valid", 64'({bus.m_aw_valid, bus.m_w_valid, bus.s_aw_ready, bus.s_w_ready}),
        64'(6'b11_00_00));
    chk("pay_aw_addr", 64'(bus.m_aw_addr), 64'h8000_0000);
    chk("pay_w_data", bus.m_w_data, 64'h1122_3344_5566_7788);
    chk("pay_strb_prot", 64'({bus.m_w_strb, bus.m_aw_prot}), 64'({8'hFF, 3'b001}));
    @(negedge clk);
    drive(15'b01_01_00_01_00_1_1_0_0_0);
    #1 chk("pay_up_ready", 64'({bus.s_aw_ready, bus.s_w_ready}), 64'(4'b0101));
    @(negedge clk);
    drive(15'b00_00_00_01_00_0_0_1_0_0);
    #1 chk("pay_b_route", 64'({bus.s_b_valid, bus.s_b_resp, bus.m_b_ready}), 64'(7'b01_0000_1));
    @(negedge clk);
    drive(15'b00_00_10_00_10_0_0_0_1_0);
    @(negedge clk); #1;
    chk("pay_ar_addr_prot", 64'({bus.m_ar_addr, bus.m_ar_prot}), 64'({32'h2000_0000, 3'b110}));
    @(negedge clk);
    drive(15'b00_00_00_00_10_0_0_0_0_1);
    #1;
    chk("pay_r_data1", bus.s_r_data[127:64], R_DATA);
    chk("pay_r_data0", bus.s_r_data[63:0], 64'h0);
    chk("pay_r_route", 64'({bus.s_r_valid, bus.s_r_resp, bus.m_r_ready}), 64'(7'b10_1000_1));

    // Two masters reading continuously: the grant order is 0,1,0,1 (round-robin) or 0,0,0,0 (fixed).
    begin
      int n_gr;
      logic [1:0] exp_oh;
      n_gr = 0;
      reset_dut();
      drive(15'b00_00_11_00_11_0_0_0_1_1);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk); #1;
        if (bus.m_ar_valid) begin
          exp_oh = (FIXED || (n_gr % 2 == 0)) ? 2'b01 : 2'b10;
          chk($sformatf("rr_grant%0d", n_gr), 64'(bus.s_ar_ready), 64'(exp_oh));
          chk($sformatf("rr_addr%0d", n_gr), 64'(bus.m_ar_addr),
              (exp_oh == 2'b01) ? 64'h1000_0000 : 64'h2000_0000);
          n_gr++;
        end
      end
      chk("rr_count", 64'(n_gr), 64'(4));
    end

    // M0 has a write and a read pending: the write goes first. Then the read stalls on s_r_ready.
    reset_dut();
    drive(15'b01_01_01_01_00_1_1_0_1_0);
    @(negedge clk); #1;
    chk("prio_write_first", 64'({bus.m_aw_valid, bus.m_w_valid, bus.m_ar_valid}), 64'(3'b110));
    @(negedge clk);
    drive(15'b00_00_01_01_00_0_0_1_1_0);
    #1 chk("prio_b", 64'({bus.m_b_ready, bus.s_b_valid}), 64'(3'b1_01));
    @(negedge clk);
    drive(15'b00_00_01_00_00_0_0_0_1_0);
    @(negedge clk); #1;
    chk("prio_read_next", 64'({bus.m_ar_valid, bus.s_ar_ready}), 64'(3'b1_01));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(15'b00_00_10_00_00_0_0_0_1_1);
      #1;
      chk($sformatf("stall%0d", c),
          64'({bus.m_r_ready, bus.s_r_valid, bus.m_ar_valid, bus.s_ar_ready}), 64'(6'b0_01_0_00));
      chk($sformatf("stall_data%0d", c), bus.s_r_data[63:0], R_DATA);
    end
    @(negedge clk);
    drive(15'b00_00_10_00_01_0_0_0_1_1);
    #1 chk("stall_release", 64'(bus.m_r_ready), 64'(1));
    @(negedge clk);
    drive('0);

    // Reset during M1's read response: the response is abandoned and rr_ptr returns to 0.
    reset_dut();
    drive(15'b00_00_01_00_11_0_0_0_1_1);
    repeat (2) @(negedge clk);
    drive(15'b00_00_10_00_11_0_0_0_1_1);
    repeat (3) @(negedge clk);
    drive(15'b00_00_10_00_00_0_0_0_1_1);
    rstn = 1'b0;
    #1 chk("rst_pre_edge", 64'(bus.s_r_valid), 64'(2'b10));
    @(negedge clk); #1;
    chk("rst_quiet", 64'(outs()), 64'(0));
    rstn = 1'b1;
    drive(15'b00_00_11_00_00_0_0_0_1_0);
    @(negedge clk); #1;
    chk("rst_rearb_m0", 64'({bus.s_ar_ready, bus.m_ar_addr}), 64'({2'b01, 32'h1000_0000}));
    @(negedge clk);
    drive('0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
